// File: rtl/rip_pkg.sv
// Shared types and constants for the rip instruction-fetch stage.
// The optional misaligned-redirect fault path is controlled by RIP_FETCH_MISALIGN_EN.
package rip_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_CODE_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  // Clears the byte-offset bits so every memory request is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/rip_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface rip_fetch_if;
  import rip_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/rip_fetch_buf.sv
// One-entry skid buffer between instruction memory and decode.
// A write wins over a same-cycle drain or flush so a word can land as the old one leaves.
module rip_fetch_buf
  import rip_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_CODE = NOP_CODE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  fetch_entry_t wr_entry,
  input  logic         drain,
  input  logic         flush,
  output logic         valid,
  output fetch_entry_t rd_entry
);

  logic         valid_reg;
  fetch_entry_t entry_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      entry_reg <= '0;
    end else if (wr_en) begin
      valid_reg <= 1'b1;
      entry_reg <= wr_entry;
    end else if (flush || drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;

  // Decode sees a harmless NOP at PC 0 whenever nothing is held.
  always_comb begin
    rd_entry.inst  = NOP_CODE;
    rd_entry.pc    = '0;
    rd_entry.fault = 1'b0;
    if (valid_reg) begin
      rd_entry = entry_reg;
    end
  end

endmodule

// File: rtl/rip_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word request at a time,
// and feeds decode through a 1-entry buffer. Optional fault path: RIP_FETCH_MISALIGN_EN.
module rip_fetch
  import rip_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_CODE = NOP_CODE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  rip_fetch_if.master     imem,
  input  logic            ex_stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            de_ready,
  output logic [XLEN-1:0] inst_code,
  output logic [XLEN-1:0] if_pc
`ifdef RIP_FETCH_MISALIGN_EN
  ,
  output logic            fetch_fault
`endif
);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] req_pc_reg, req_pc_next;
  logic            squash_reg, squash_next;
  logic            halt_reg, halt_next;

  logic            buf_valid;
  logic            buf_wr;
  fetch_entry_t    buf_wr_entry;
  fetch_entry_t    buf_rd_entry;
  logic            buf_space;
  logic            req_c;
  logic            misalign;

  rip_fetch_buf #(
    .NOP_CODE (NOP_CODE)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (buf_wr),
    .wr_entry (buf_wr_entry),
    .drain    (de_ready),
    .flush    (redirect),
    .valid    (buf_valid),
    .rd_entry (buf_rd_entry)
  );

  assign de_ready  = buf_valid & ~ex_stall & ~redirect;
  assign buf_space = ~buf_valid | de_ready;
  assign inst_code = buf_rd_entry.inst;
  assign if_pc     = buf_rd_entry.pc;

`ifdef RIP_FETCH_MISALIGN_EN
  assign misalign    = redirect & (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = de_ready & buf_rd_entry.fault;
`else
  logic fault_unused;
  assign misalign     = 1'b0;
  assign fault_unused = buf_rd_entry.fault;
`endif

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = word_align(pc_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
      squash_reg <= 1'b0;
      halt_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
      squash_reg <= squash_next;
      halt_reg   <= halt_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    req_pc_next        = req_pc_reg;
    squash_next        = squash_reg;
    halt_next          = halt_reg;
    req_c              = 1'b0;
    buf_wr             = 1'b0;
    buf_wr_entry.inst  = imem.imem_rdata;
    buf_wr_entry.pc    = req_pc_reg;
    buf_wr_entry.fault = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = REQ;
      end

      // Once raised, the request stays up: the buffer is empty and nothing refills it here.
      REQ: begin
        req_c = buf_space & ~halt_reg;
        if (req_c && imem.imem_gnt) begin
          req_pc_next = pc_reg;
          state_next  = WAIT;
          squash_next = redirect;
        end
      end

      WAIT: begin
        if (imem.imem_rvalid) begin
          state_next  = REQ;
          squash_next = 1'b0;
          if (!squash_reg && !redirect) begin
            buf_wr  = 1'b1;
            pc_next = req_pc_reg + 32'd4;
          end
        end else if (redirect) begin
          squash_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Redirect overrides sequential PC flow in every state.
    if (redirect) begin
      pc_next   = word_align(redirect_pc);
      halt_next = misalign;
      if (misalign) begin
        buf_wr             = 1'b1;
        buf_wr_entry.inst  = NOP_CODE;
        buf_wr_entry.pc    = redirect_pc;
        buf_wr_entry.fault = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rip_fetch.sv
// Self-checking bench for rip_fetch: randomized memory/stall/redirect traffic checked
// every cycle against a transaction-level model, plus directed literal checks.
module tb_rip_fetch;
  import rip_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        de_ready;
  logic [31:0] inst_code;
  logic [31:0] if_pc;
`ifdef RIP_FETCH_MISALIGN_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  rip_fetch_if bus ();

  rip_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_CODE (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .ex_stall    (ex_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .de_ready    (de_ready),
    .inst_code   (inst_code),
    .if_pc       (if_pc)
`ifdef RIP_FETCH_MISALIGN_EN
    ,
    .fetch_fault (fetch_fault)
`endif
  );

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // memory model knobs and state
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        mem_out = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  // reference model: what decode should see and what fetch should ask for
  logic        m_run, m_bv, m_bf, m_out, m_stale, m_halt;
  logic [31:0] m_bpc, m_binst, m_fpc, m_oaddr;

  logic        last_de, last_req, last_fault;
  logic [31:0] last_addr, last_inst, last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_bv = 0; m_bf = 0; m_out = 0; m_stale = 0; m_halt = 0;
    m_bpc = 0; m_binst = 32'h13; m_fpc = 32'h0; m_oaddr = 0;
    mem_out = 0; mem_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; ex_stall = 0; redirect = 0; redirect_pc = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      #1;
      chk1("rst_req", bus.imem_req, 1'b0);
      chk1("rst_de_ready", de_ready, 1'b0);
      chk32("rst_inst_code", inst_code, 32'h0000_0013);
      chk32("rst_if_pc", if_pc, 32'h0);
    end
  endtask

  // One clock: drive inputs, act as memory, compare all outputs, advance the model.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic exp_de, exp_req, rsp, gnt_now, mis, new_word;
    logic [31:0] tgt, fpc_old;
    @(negedge clk);
    rst = 0; ex_stall = st; redirect = rd; redirect_pc = rpc;
    rsp = 1'b0;
    if (mem_out) begin
      mem_cnt--;
      if (mem_cnt == 0) rsp = 1'b1;
    end
    bus.imem_rvalid = rsp;
    bus.imem_rdata  = rsp ? mem_word(mem_addr) : $urandom;
    bus.imem_gnt    = 1'b0;
    #1;
    gnt_now = bus.imem_req && !mem_out && ($urandom_range(0, 99) < gnt_pct);
    bus.imem_gnt = gnt_now;
    #1;

    exp_de  = m_bv && !st && !rd;
    exp_req = m_run && !m_out && !m_halt && (!m_bv || exp_de);
    chk1("de_ready", de_ready, exp_de);
    chk1("imem_req", bus.imem_req, exp_req);
    if (exp_req) chk32("imem_addr", bus.imem_addr, m_fpc);
    chk32("inst_code", inst_code, m_bv ? m_binst : 32'h0000_0013);
    chk32("if_pc", if_pc, m_bv ? m_bpc : 32'h0);
`ifdef RIP_FETCH_MISALIGN_EN
    chk1("fetch_fault", fetch_fault, exp_de && m_bf);
    last_fault = fetch_fault;
`else
    last_fault = 1'b0;
`endif
    last_de = de_ready; last_req = bus.imem_req; last_addr = bus.imem_addr;
    last_inst = inst_code; last_pc = if_pc;
    if (de_ready) delivered++;

    if (rsp) mem_out = 1'b0;
    if (gnt_now) begin
      mem_out  = 1'b1;
      mem_cnt  = $urandom_range(lat_min, lat_max);
      mem_addr = bus.imem_addr;
    end

    mis = 1'b0;
`ifdef RIP_FETCH_MISALIGN_EN
    mis = rd && (rpc[1:0] != 2'b00);
`endif
    tgt      = {rpc[31:2], 2'b00};
    fpc_old  = m_fpc;
    new_word = rsp && m_out && !m_stale && !rd;
    if (rd) begin
      m_fpc  = tgt;
      m_halt = mis;
      if (mis) begin
        m_bv = 1; m_binst = 32'h0000_0013; m_bpc = rpc; m_bf = 1;
      end else begin
        m_bv = 0;
      end
    end else if (new_word) begin
      m_bv = 1; m_binst = mem_word(m_oaddr); m_bpc = m_oaddr; m_bf = 0;
      m_fpc = m_oaddr + 32'd4;
    end else if (exp_de) begin
      m_bv = 0;
    end
    if (rsp && m_out) m_out = 0;
    if (exp_req && gnt_now) begin
      m_out = 1; m_stale = rd; m_oaddr = fpc_old;
    end else if (rd && m_out) begin
      m_stale = 1;
    end
    m_run = 1;
  endtask

  task automatic wait_de(input string name, input int bound);
    int n = 0;
    do begin
      step(1'b0, 1'b0, 32'h0);
      n++;
    end while (!last_de && n < bound);
    if (!last_de) begin
      checks++; errors++;
      $display("FAIL %s no de_ready within %0d cycles", name, bound);
    end
  endtask

  task automatic stall_until_full(input string name);
    int n = 0;
    do begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end while (!m_bv && n < 30);
    chk1({name, "_buffer_filled"}, last_de, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_inst, saved_pc;
    int n, reqs;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    model_reset();

    // first fetch: 0-cycle grant, 1-cycle response
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    wait_de("t1_first", 10);
    chk32("t1_inst", last_inst, 32'h0050_0093);
    chk32("t1_if_pc", last_pc, 32'h0);
    chk1("t1_next_req", last_req, 1'b1);
    chk32("t1_next_addr", last_addr, 32'h4);

    // stall with full buffer
    stall_until_full("t2");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (i == 0) begin saved_inst = last_inst; saved_pc = last_pc; end
      chk1("t2_stall_de", last_de, 1'b0);
      chk1("t2_stall_req", last_req, 1'b0);
      if (i > 0) chk32("t2_stall_inst", last_inst, saved_inst);
    end
    chk32("t2_held_word", saved_inst, mem_word(saved_pc));
    step(1'b0, 1'b0, 32'h0);
    chk1("t2_release_de", last_de, 1'b1);
    chk32("t2_release_inst", last_inst, saved_inst);
    chk32("t2_release_pc", last_pc, saved_pc);

    // redirect during WAIT with 3-cycle latency
    lat_min = 3; lat_max = 3;
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0); n++; end while (!(m_out && mem_cnt == 3) && n < 20);
    step(1'b0, 1'b1, 32'h0000_0100);
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0); n++; end while (!last_req && n < 10);
    chk32("t3_addr", last_addr, 32'h0000_0100);
    wait_de("t3_deliver", 20);
    chk32("t3_if_pc", last_pc, 32'h0000_0100);
    chk32("t3_inst", last_inst, 32'h5A5A_0113);

    // redirect and stall together with a full buffer
    lat_min = 1; lat_max = 1;
    stall_until_full("t4");
    step(1'b1, 1'b1, 32'h0000_0200);
    chk1("t4_de", last_de, 1'b0);
    wait_de("t4_deliver", 20);
    chk32("t4_if_pc", last_pc, 32'h0000_0200);

    // PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_de("t5_first", 20);
    chk32("t5_if_pc0", last_pc, 32'hFFFF_FFFC);
    wait_de("t5_second", 20);
    chk32("t5_if_pc1", last_pc, 32'h0000_0000);

`ifdef RIP_FETCH_MISALIGN_EN
    step(1'b0, 1'b1, 32'h0000_0102);
    wait_de("t6_fault", 10);
    chk1("t6_fault", last_fault, 1'b1);
    chk32("t6_inst", last_inst, 32'h0000_0013);
    chk32("t6_if_pc", last_pc, 32'h0000_0102);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (last_req) reqs++;
    end
    chk32("t6_no_req", reqs, 0);
    step(1'b0, 1'b1, 32'h0000_0300);
`else
    reqs = 0;
`endif

    // reset while a response is in flight
    lat_min = 3; lat_max = 3;
    n = 0;
    do begin step(1'b0, 1'b0, 32'h0); n++; end while (!m_out && n < 20);
    do_reset();
    wait_de("t7_after_reset", 20);
    chk32("t7_if_pc", last_pc, 32'h0);
    chk32("t7_inst", last_inst, 32'h0050_0093);

    // randomized traffic
    gnt_pct = 60; lat_min = 1; lat_max = 4;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      logic st, rd;
      logic [31:0] rpc;
      int r;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 19) == 0);
      r  = $urandom_range(0, 7);
      if (r == 0) rpc = 32'hFFFF_FFF8;
      else if (r == 1) rpc = $urandom & 32'h0000_FFFF;
      else rpc = $urandom & 32'h0000_FFFC;
      step(st, rd, rpc);
    end
    chk1("progress", delivered >= 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rip_fetch.md
Name: rip_fetch

Overview:
- Instruction-fetch stage. Owns the PC and issues word requests to instruction memory.
- Memory handshake: valid/ready, variable latency, one request outstanding at a time.
- Buffers the returned word and hands it to the decode stage through `inst_code` / `de_ready`.
- Applies EX-stage stall and PC-redirect (branch/jump/trap) control.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_CODE, 32'h0000_0013, word driven on `inst_code` when no instruction is valid (ADDI x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned request address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction word
- ex_stall  in  1  EX stage holding; decode must not advance
- redirect  in  1  branch/jump/trap taken this cycle
- redirect_pc  in  32  target PC
- de_ready  out  1  `inst_code` is valid and decode must capture it this cycle
- inst_code  out  32  instruction to decode
- if_pc  out  32  PC of `inst_code`

Behaviour:
Reset values:
- pc=RESET_PC, state=IDLE, imem_req=0, de_ready=0, inst_code=NOP_CODE, if_pc=0, buffer empty, squash=0.

FSM:
- IDLE: one cycle after reset, then go to REQ.
- REQ:
  - Drive imem_req=1, imem_addr={pc[31:2],2'b00}.
  - Request and address are held stable until imem_gnt.
  - On gnt: record req_pc=pc, go to WAIT.
  - Entered only when the buffer is empty, or is being drained this cycle.
- WAIT:
  - imem_req=0.
  - On imem_rvalid with squash=0: write {imem_rdata, req_pc} to the 1-entry buffer, pc<=req_pc+4, go to REQ.
  - On imem_rvalid with squash=1: discard the response, clear squash, go to REQ.

Output rules:
- de_ready = buf_valid & ~ex_stall & ~redirect (combinational).
- inst_code and if_pc are the buffer contents when buf_valid=1; otherwise NOP_CODE and 0.
- The buffer drains when de_ready=1.
- Zero-bubble return path: if the response arrives in the same cycle the buffer drains, the response is written.
- If the buffer is full and not draining, the FSM holds in REQ without asserting imem_req. No fetch-ahead beyond one word.

Redirect (highest priority, any state):
- pc<=redirect_pc, buffer cleared, de_ready=0 that cycle.
- In WAIT: set squash=1.
- In REQ with gnt in the same cycle: the granted request is squashed (go to WAIT with squash=1).
- In REQ without gnt: the address switches to redirect_pc next cycle. imem_req may drop for one cycle; this is the single allowed exception to the hold-until-gnt rule.

Stall and reset:
- ex_stall: buffer holds and de_ready=0. Fetch continues only until the buffer is full.
- Simultaneous redirect and ex_stall: redirect wins.
- Reset mid-WAIT: the FSM returns to IDLE. Memory must drop in-flight responses on reset.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
RIP_FETCH_MISALIGN_EN
- Defined:
  - Adds output `fetch_fault` (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 issues no memory request.
  - The buffer is loaded with {NOP_CODE, redirect_pc} and fault=1.
  - `fetch_fault` is asserted alongside de_ready for that entry.
  - The FSM then idles in REQ with no request until the next redirect.
- Undefined:
  - Port absent.
  - Low address bits are ignored; the fetch uses {pc[31:2],2'b00}.

Decomposition:
- Package `rip_pkg`: fetch state enum (IDLE, REQ, WAIT), NOP_CODE, RESET_PC default, XLEN=32.
- One natural sub-module: `rip_fetch_buf`, the 1-entry skid buffer holding {inst, pc, fault} with valid, write and drain ports.
- The FSM and PC stay in the top module.

Test Plan:
- Reset, memory with 0-cycle grant and 1-cycle rvalid returning 32'h00500093: de_ready pulses with inst_code=32'h00500093, if_pc=0. Next request address is 4.
- ex_stall held 5 cycles while the buffer is full: de_ready=0 throughout, imem_req=0, inst_code stable. First cycle after release: de_ready=1, same word.
- Redirect to 32'h0000_0100 during WAIT (3-cycle memory latency): stale response dropped, no de_ready for it. Next imem_addr=32'h100, then if_pc=32'h100.
- Redirect and ex_stall high in the same cycle with the buffer full: buffer flushed, de_ready=0. The next delivered if_pc equals the redirect target.
- PC at 32'hFFFF_FFFC, back-to-back responses: if_pc sequence FFFF_FFFC, 0000_0000.
- RIP_FETCH_MISALIGN_EN defined, redirect to 32'h0000_0102: fetch_fault=1 with de_ready, inst_code=NOP_CODE, if_pc=32'h102, no imem_req issued.
